// File: rtl/lsu_pkg.sv
// Shared state encoding, funct3 codes and access-size helper for the load/store unit.
package lsu_pkg;

    localparam int LSU_XLEN    = 64;
    localparam int LSU_ADDR_HI = 10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_bytes = 4'd1;
            F3_H, F3_HU: size_bytes = 4'd2;
            F3_W, F3_WU: size_bytes = 4'd4;
            default:     size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake and data-memory port of the load/store unit.
interface lsu_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    logic            mem_read;
    logic            mem_write;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    // Environment side: execute stage plus data memory.
    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane extraction with sign/zero extension, and sub-word merge into a 64-bit word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [63:0] i_rdata,
    input  logic [63:0] i_wdata,
    input  logic [2:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [63:0] o_ext,
    output logic [63:0] o_merged
);

    logic [63:0] w_rsh;
    logic [63:0] w_wsh;
    logic [3:0]  w_size;

    assign w_rsh  = i_rdata >> {i_off, 3'b000};
    assign w_wsh  = i_wdata << {i_off, 3'b000};
    assign w_size = size_bytes(i_funct3);

    always_comb begin
        o_ext = w_rsh;
        case (i_funct3)
            F3_B:    o_ext = {{56{w_rsh[7]}},  w_rsh[7:0]};
            F3_H:    o_ext = {{48{w_rsh[15]}}, w_rsh[15:0]};
            F3_W:    o_ext = {{32{w_rsh[31]}}, w_rsh[31:0]};
            F3_BU:   o_ext = {56'd0, w_rsh[7:0]};
            F3_HU:   o_ext = {48'd0, w_rsh[15:0]};
            F3_WU:   o_ext = {32'd0, w_rsh[31:0]};
            default: o_ext = w_rsh;
        endcase
    end

    // Requests are aligned before they get here, so the lane never crosses the word.
    always_comb begin
        o_merged = i_rdata;
        for (int i = 0; i < 8; i++) begin
            if ((4'(i) >= {1'b0, i_off}) && (4'(i) < ({1'b0, i_off} + w_size)))
                o_merged[i*8 +: 8] = w_wsh[i*8 +: 8];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per handshake, sub-word stores via read-modify-write.
//
//  state  | meaning
//  IDLE   | ready for a request; errors go straight to RESP
//  RD     | load read; capture extended lane
//  RMW_RD | sub-word store read; capture merged word
//  WR     | single-cycle memory write
//  RESP   | response held until resp_ready
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN    = LSU_XLEN,
    parameter int ADDR_HI = LSU_ADDR_HI
)(
    input logic  clk,
    input logic  rst_n,
    lsu_if.slave bus
);

    lsu_state_e      r_state;
    lsu_state_e      w_next;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic [XLEN-1:0] r_merged;
    logic            r_err;

    logic            w_misaligned;
    logic            w_illegal;
    logic            w_out_of_range;
    logic            w_err;
    logic            w_accept;
    logic            w_req_ready;
    logic            w_resp_valid;
    logic            w_mem_read;
    logic            w_mem_write;
    logic [XLEN-1:0] w_ext;
    logic [XLEN-1:0] w_merged;

    assign w_misaligned   = (bus.req_addr[2:0] & 3'(size_bytes(bus.req_funct3) - 4'd1)) != 3'b000;
    assign w_illegal      = (bus.req_funct3 == 3'b111) || (bus.req_write && bus.req_funct3[2]);
    assign w_out_of_range = (bus.req_addr >> (ADDR_HI + 1)) != '0;
    assign w_err          = w_misaligned || w_illegal || w_out_of_range;
    assign w_accept       = bus.req_valid && w_req_ready;

    lsu_lane_align u_align (
        .i_rdata  (bus.mem_rdata),
        .i_wdata  (r_wdata),
        .i_off    (r_addr[2:0]),
        .i_funct3 (r_funct3),
        .o_ext    (w_ext),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (w_err)                      w_next = RESP;
                    else if (!bus.req_write)        w_next = RD;
                    else if (bus.req_funct3 == F3_D) w_next = WR;
                    else                            w_next = RMW_RD;
                end
            end
            RD: begin
                w_mem_read = 1'b1;
                w_next     = RESP;
            end
            RMW_RD: begin
                w_mem_read = 1'b1;
                w_next     = WR;
            end
            WR: begin
                w_mem_write = 1'b1;
                w_next      = RESP;
            end
            RESP: begin
                w_resp_valid = 1'b1;
                if (bus.resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_merged <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
                r_err    <= w_err;
                r_rdata  <= '0;
            end
            if (r_state == RD)     r_rdata  <= w_ext;
            if (r_state == RMW_RD) r_merged <= w_merged;
        end
    end

    // Memory strobes come only from state, so an async reset kills a pending write at once.
    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_rdata = (r_state == RESP) ? r_rdata : '0;
    assign bus.resp_err   = (r_state == RESP) && r_err;
    assign bus.mem_read   = w_mem_read;
    assign bus.mem_write  = w_mem_write;
    assign bus.mem_addr   = (w_mem_read || w_mem_write) ? {r_addr[XLEN-1:3], 3'b000} : '0;
    assign bus.mem_wdata  = w_mem_write ? ((r_funct3 == F3_D) ? r_wdata : r_merged) : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-level transaction model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    lsu_if #(.XLEN(64)) bus();

    load_store_unit #(.XLEN(64), .ADDR_HI(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [256];
    logic [63:0] ref_mem [256];
    logic        mem_init_done = 1'b0;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_mrd    = 0;
    int   n_mwr    = 0;
    bit   chk_en   = 1'b0;

    logic [63:0] exp_rdata;
    logic [63:0] exp_maddr;
    logic [63:0] exp_wword;
    logic        exp_err;

    function automatic logic [63:0] init_word(input int i);
        return (64'h9E37_79B9_7F4A_7C15 * 64'(i + 1)) ^ 64'h0F0F_3C3C_A5A5_5A5A;
    endfunction

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[10:3]] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_addr[10:3]];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Transaction-level model: error rules, byte lanes, extension, latency and memory traffic.
    task automatic model(input bit wr, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, output logic m_err, output logic [63:0] m_rd,
                         output logic [63:0] m_word, output int m_lat, output int m_nrd,
                         output int m_nwr);
        int sz, off, idx;
        logic [63:0] w;
        sz  = 1 << f3[1:0];
        off = int'(addr % 64'd8);
        idx = int'((addr / 64'd8) % 64'd256);
        m_err  = (f3 == 3'd7) || (wr && f3[2]) || ((addr % 64'(sz)) != 64'd0) || (addr >= 64'd2048);
        m_rd   = '0;
        m_word = '0;
        m_lat  = 1;
        m_nrd  = 0;
        m_nwr  = 0;
        if (m_err) return;
        w = ref_mem[idx];
        if (!wr) begin
            for (int b = 0; b < sz; b++) m_rd[8*b +: 8] = w[8*(off+b) +: 8];
            if (!f3[2] && sz < 8 && m_rd[8*sz-1])
                for (int b = sz; b < 8; b++) m_rd[8*b +: 8] = 8'hFF;
            m_lat = 2;
            m_nrd = 1;
        end else begin
            for (int b = 0; b < sz; b++) w[8*(off+b) +: 8] = wd[8*b +: 8];
            ref_mem[idx] = w;
            m_word = w;
            m_nwr  = 1;
            m_nrd  = (sz == 8) ? 0 : 1;
            m_lat  = (sz == 8) ? 2 : 3;
        end
    endtask

    // Per-cycle compare of response and memory-port outputs against the model's expectation.
    always @(negedge clk) begin
        if (bus.mem_read)  n_mrd++;
        if (bus.mem_write) n_mwr++;
        if (chk_en) begin
            chk("rd_wr_exclusive", 64'(bus.mem_read && bus.mem_write), 64'd0);
            if (bus.resp_valid) begin
                chk("resp_rdata", bus.resp_rdata, exp_rdata);
                chk("resp_err", 64'(bus.resp_err), 64'(exp_err));
            end
            if (bus.mem_read || bus.mem_write) chk("mem_addr", bus.mem_addr, exp_maddr);
            if (bus.mem_write) chk("mem_wdata", bus.mem_wdata, exp_wword);
        end
    end

    task automatic do_txn(input bit wr, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd, input int hold, output logic [63:0] got_rd,
                          output logic got_err, output int got_lat);
        logic        m_err;
        logic [63:0] m_rd, m_word;
        int          m_lat, m_nrd, m_nwr, rd0, wr0;
        model(wr, f3, addr, wd, m_err, m_rd, m_word, m_lat, m_nrd, m_nwr);
        exp_rdata = m_rd;
        exp_err   = m_err;
        exp_wword = m_word;
        exp_maddr = {addr[63:3], 3'b000};
        @(negedge clk);
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.resp_ready = (hold == 0);
        rd0 = n_mrd;
        wr0 = n_mwr;
        @(negedge clk);
        bus.req_valid = 1'b0;
        got_lat = 1;
        while (!bus.resp_valid && got_lat < 10) begin
            @(negedge clk);
            got_lat++;
        end
        chk("resp_latency", 64'(got_lat), 64'(m_lat));
        got_rd  = bus.resp_rdata;
        got_err = bus.resp_err;
        if (hold > 0) begin
            bus.req_valid  = 1'b1;
            bus.req_write  = 1'b0;
            bus.req_funct3 = F3_D;
            bus.req_addr   = 64'h0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
                chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
                chk("bp_rdata_stable", bus.resp_rdata, got_rd);
            end
            bus.req_valid  = 1'b0;
            bus.resp_ready = 1'b1;
        end
        @(negedge clk);
        chk("resp_complete", 64'(bus.resp_valid), 64'd0);
        bus.resp_ready = 1'b0;
        chk("mem_read_count", 64'(n_mrd - rd0), 64'(m_nrd));
        chk("mem_write_count", 64'(n_mwr - wr0), 64'(m_nwr));
    endtask

    logic [63:0] g_rd, t_addr, t_wd, w_before;
    logic        g_err;
    int          g_lat, t_sz, t_off, t_hold, wr0;
    bit          t_wr;
    logic [2:0]  t_f3;

    initial begin
        #1ms;
        $display("FAIL watchdog_timeout got=%0t exp=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
        chk("rst_mem_read", 64'(bus.mem_read), 64'd0);
        chk("rst_mem_write", 64'(bus.mem_write), 64'd0);
        chk("rst_mem_addr", bus.mem_addr, 64'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        do_txn(1'b1, F3_D, 64'h10, 64'h1122334455667788, 0, g_rd, g_err, g_lat);
        chk("sd_latency", 64'(g_lat), 64'd2);
        chk("sd_word", mem[2], 64'h1122334455667788);
        do_txn(1'b0, F3_D, 64'h10, 64'h0, 0, g_rd, g_err, g_lat);
        chk("ld_data", g_rd, 64'h1122334455667788);
        chk("ld_latency", 64'(g_lat), 64'd2);
        do_txn(1'b1, F3_B, 64'h13, 64'hAB, 0, g_rd, g_err, g_lat);
        chk("sb_latency", 64'(g_lat), 64'd3);
        chk("sb_word", mem[2], 64'h11223344AB667788);

        do_txn(1'b1, F3_D, 64'h0, 64'h00000000F0008000, 0, g_rd, g_err, g_lat);
        do_txn(1'b0, F3_H, 64'h0, 64'h0, 0, g_rd, g_err, g_lat);
        chk("lh_ext", g_rd, 64'hFFFFFFFFFFFF8000);
        do_txn(1'b0, F3_HU, 64'h0, 64'h0, 0, g_rd, g_err, g_lat);
        chk("lhu_ext", g_rd, 64'h0000000000008000);
        do_txn(1'b0, F3_W, 64'h0, 64'h0, 0, g_rd, g_err, g_lat);
        chk("lw_ext", g_rd, 64'hFFFFFFFFF0008000);
        do_txn(1'b0, F3_B, 64'h7, 64'h0, 0, g_rd, g_err, g_lat);
        chk("lb_top", g_rd, 64'h0);

        do_txn(1'b0, F3_W, 64'h12, 64'h0, 0, g_rd, g_err, g_lat);
        chk("err_misaligned", 64'(g_err), 64'd1);
        chk("err_misaligned_lat", 64'(g_lat), 64'd1);
        do_txn(1'b1, F3_BU, 64'h0, 64'h55, 0, g_rd, g_err, g_lat);
        chk("err_store_unsigned", 64'(g_err), 64'd1);
        do_txn(1'b0, F3_D, 64'h800, 64'h0, 0, g_rd, g_err, g_lat);
        chk("err_out_of_range", 64'(g_err), 64'd1);
        do_txn(1'b0, 3'b111, 64'h0, 64'h0, 0, g_rd, g_err, g_lat);
        chk("err_illegal_f3", 64'(g_err), 64'd1);

        do_txn(1'b0, F3_D, 64'h10, 64'h0, 5, g_rd, g_err, g_lat);
        chk("bp_data", g_rd, 64'h11223344AB667788);

        for (int n = 0; n < 300; n++) begin
            t_wr = 1'($urandom_range(0, 1));
            t_f3 = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            if (t_wr && t_f3[2] && $urandom_range(0, 3) != 0) t_f3[2] = 1'b0;
            t_sz  = 1 << t_f3[1:0];
            t_off = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) t_off = t_off & ~(t_sz - 1);
            t_addr = 64'($urandom_range(0, 15)) * 64'd8 + 64'(t_off);
            if ($urandom_range(0, 19) == 0) t_addr = t_addr | (64'd1 << $urandom_range(11, 63));
            t_wd   = {$urandom, $urandom};
            t_hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_txn(t_wr, t_f3, t_addr, t_wd, t_hold, g_rd, g_err, g_lat);
        end

        chk_en = 1'b0;
        @(negedge clk);
        w_before       = mem[3];
        wr0            = n_mwr;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = F3_B;
        bus.req_addr   = 64'h1A;
        bus.req_wdata  = 64'h5A;
        @(negedge clk);
        chk("rmw_in_read", 64'(bus.mem_read), 64'd1);
        bus.req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("mid_rst_mem_read", 64'(bus.mem_read), 64'd0);
        chk("mid_rst_mem_write", 64'(bus.mem_write), 64'd0);
        chk("mid_rst_mem_addr", bus.mem_addr, 64'd0);
        chk("mid_rst_mem_wdata", bus.mem_wdata, 64'd0);
        chk("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_write", 64'(n_mwr - wr0), 64'd0);
        chk("mid_rst_word", mem[3], w_before);
        chk_en = 1'b1;

        do_txn(1'b0, F3_D, 64'h18, 64'h0, 0, g_rd, g_err, g_lat);
        for (int i = 0; i < 256; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
